// File: rtl/gtx_tx_framer.sv
// rtl/gtx_tx_framer.sv - fixed-length LocalLink TX framer: header, payload, checksum trailer
module gtx_tx_framer #(
  parameter int unsigned PAYLOAD_WORDS = 94,
  parameter logic [7:0]  HDR_MAGIC     = 8'hA5
) (
  input  logic        clk_gtp,
  input  logic        rst_gtp,
  input  logic        channel_up,
  input  logic [15:0] up_data,
  input  logic        up_valid,
  output logic        up_ready,
  output logic [15:0] gtx_tx_data,
  output logic        gtx_tx_sof_n,
  output logic        gtx_tx_eof_n,
  output logic        gtx_tx_src_rdy_n,
  input  logic        gtx_tx_dst_rdy_n,
  output logic [15:0] frame_cnt,
  output logic        frame_abort
);

  localparam int CW = $clog2(PAYLOAD_WORDS + 1);
  localparam logic [CW-1:0] PAY_LAST = CW'(PAYLOAD_WORDS);

  typedef enum logic [1:0] {IDLE, HDR, PAY, CRC} state_t;

  state_t        state, state_nx;
  logic [15:0]   data_nx;
  logic          sof_nx, eof_nx, src_nx;
  logic [7:0]    seq, seq_nx;
  logic [15:0]   checksum, checksum_nx;
  logic [CW-1:0] pay_cnt, pay_cnt_nx;
  logic [15:0]   frame_cnt_nx;
  logic          frame_abort_nx;
  logic          transfer;

  assign transfer = !gtx_tx_src_rdy_n && !gtx_tx_dst_rdy_n;

  always_comb begin
    state_nx       = state;
    data_nx        = gtx_tx_data;
    sof_nx         = gtx_tx_sof_n;
    eof_nx         = gtx_tx_eof_n;
    src_nx         = gtx_tx_src_rdy_n;
    seq_nx         = seq;
    checksum_nx    = checksum;
    pay_cnt_nx     = pay_cnt;
    frame_cnt_nx   = frame_cnt;
    frame_abort_nx = 1'b0;
    up_ready       = 1'b0;

    case (state)
      IDLE: begin
        // Start decision only peeks at up_valid; the word itself is taken in PAY.
        if (channel_up && up_valid) begin
          data_nx     = {HDR_MAGIC, seq};
          src_nx      = 1'b0;
          sof_nx      = 1'b0;
          eof_nx      = 1'b1;
          checksum_nx = '0;
          state_nx    = HDR;
        end
      end
      HDR: begin
        if (transfer) begin
          src_nx     = 1'b1;
          sof_nx     = 1'b1;
          pay_cnt_nx = '0;
          state_nx   = PAY;
        end
      end
      PAY: begin
        up_ready = (pay_cnt < PAY_LAST) && (gtx_tx_src_rdy_n || transfer);
        if (up_valid && up_ready) begin
          data_nx     = up_data;
          src_nx      = 1'b0;
          sof_nx      = 1'b1;
          eof_nx      = 1'b1;
          pay_cnt_nx  = pay_cnt + 1'b1;
          checksum_nx = checksum + up_data;
        end else if (transfer) begin
          if (pay_cnt == PAY_LAST) begin
            data_nx  = checksum;
            src_nx   = 1'b0;
            eof_nx   = 1'b0;
            state_nx = CRC;
          end else begin
            src_nx = 1'b1;
          end
        end
      end
      CRC: begin
        if (transfer) begin
          src_nx       = 1'b1;
          eof_nx       = 1'b1;
          seq_nx       = seq + 8'd1;
          frame_cnt_nx = frame_cnt + 16'd1;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Channel loss wins over any same-cycle transfer; the partial frame is dropped.
    if (state != IDLE && !channel_up) begin
      up_ready       = 1'b0;
      state_nx       = IDLE;
      src_nx         = 1'b1;
      sof_nx         = 1'b1;
      eof_nx         = 1'b1;
      seq_nx         = seq;
      frame_cnt_nx   = frame_cnt;
      checksum_nx    = checksum;
      pay_cnt_nx     = pay_cnt;
      frame_abort_nx = 1'b1;
    end
  end

  always_ff @(posedge clk_gtp) begin
    if (rst_gtp) begin
      state            <= IDLE;
      gtx_tx_data      <= '0;
      gtx_tx_sof_n     <= 1'b1;
      gtx_tx_eof_n     <= 1'b1;
      gtx_tx_src_rdy_n <= 1'b1;
      seq              <= '0;
      checksum         <= '0;
      pay_cnt          <= '0;
      frame_cnt        <= '0;
      frame_abort      <= 1'b0;
    end else begin
      state            <= state_nx;
      gtx_tx_data      <= data_nx;
      gtx_tx_sof_n     <= sof_nx;
      gtx_tx_eof_n     <= eof_nx;
      gtx_tx_src_rdy_n <= src_nx;
      seq              <= seq_nx;
      checksum         <= checksum_nx;
      pay_cnt          <= pay_cnt_nx;
      frame_cnt        <= frame_cnt_nx;
      frame_abort      <= frame_abort_nx;
    end
  end

endmodule
